multi_rate_divider: RTL
=======================

// Module: multi_rate_divider
// PURPOSE
//  Parametrised successor to the fixed power-of-two dividers. Generates NUM_CH
//  independent clock-enable channels from CLK, each with an exact integer divisor.
//  Each channel produces a one-cycle TICK strobe and a near-50% square wave SQ.
//  Divisors are reprogrammable at runtime through a valid/ready load port.
//  Consumers include the elevator timers, display multiplexing and LED blinkers.
//  All logic runs on CLK; outputs are used as enables, never as derived clocks.
// PARAMETERS
//  NUM_CH    3                                  number of channels
//  CNT_W     27                                 counter/divisor width; max divisor 2^CNT_W-1
//  DIV_INIT  {27'd100000,27'd50000000,27'd100000000}  reset divisors packed
//            NUM_CH*CNT_W; ch i = bits [i*CNT_W +: CNT_W] (ch0 1Hz, ch1 2Hz, ch2 1kHz @100MHz)
// PORTS
//  CLK         in   1                 system clock, 100 MHz
//  RST_N       in   1                 synchronous reset, active low
//  EN          in   NUM_CH            per-channel run enable
//  LOAD_VALID  in   1                 divisor load request
//  LOAD_READY  out  1                 load buffer free
//  LOAD_CH     in   clog2(NUM_CH)     target channel (min width 1)
//  LOAD_DIV    in   CNT_W             new divisor
//  TICK        out  NUM_CH            1-cycle strobe, once per divisor period
//  SQ          out  NUM_CH            square wave, period = divisor cycles
// BEHAVIOUR
//  Reset (RST_N=0 at posedge): D_i<=DIV_INIT slice, C_i<=0, TICK<=0, SQ<=0.
//   Pending load dropped; LOAD_READY<=1. A reset mid-period or mid-load aborts cleanly.
//  Legal divisor range is 2..2^CNT_W-1. DIV_INIT or LOAD_DIV values 0 or 1 clamp to 2.
//  Counter, per channel, at each posedge with EN_i=1:
//   term_i = (C_i == D_i-1).
//   C_i <= term_i ? 0 : C_i+1.
//   TICK_i <= term_i.
//   SQ_i <= (Cnext_i >= D_i-(D_i>>1)), where Cnext_i is the value loaded into C_i.
//  Resulting output timing:
//   First TICK_i is high in the cycle after the D-th enabled edge; then every D cycles.
//   SQ duty: high floor(D/2) cycles, low ceil(D/2) cycles. SQ rises mid-period and falls when C wraps to 0.
//  EN_i=0: C_i and SQ_i hold; TICK_i<=0. Resuming continues from the held count (no restart).
//  Load port: single-entry buffer, with states IDLE and PEND.
//   IDLE: LOAD_READY=1.
//    LOAD_VALID=1 latches LOAD_CH/LOAD_DIV (clamped), goes to PEND; LOAD_READY=0 from next cycle.
//    If LOAD_CH >= NUM_CH, the request is accepted and discarded; state stays IDLE.
//   PEND: applied when the target channel has EN=1 and term=1, or immediately if its EN=0.
//    On apply: D<=new value; C<=0 (EN=1 wrap or EN=0 restart); SQ<=0; return to IDLE.
//    The TICK for the completing period still fires; the new period starts at C=0.
//    LOAD_READY=1 the cycle after apply. LOAD_VALID while LOAD_READY=0 is ignored.
//  Channels with no load pending are never disturbed by a load to another channel.
//  Arithmetic: all compares and increments are CNT_W bits. D>=2 guarantees D-1 never underflows.
// TESTING
//  Use NUM_CH=3, CNT_W=8, DIV_INIT={2,5,4} (ch0=4, ch1=5, ch2=2) for every scenario below.
//  1 Release reset with EN=111 -> TICK0 high in cycle after edge 4, then every 4;
//    TICK2 every 2 cycles; all outputs 0 during reset.
//  2 Duty: ch1 (D=5) -> SQ1 high 2 cycles, low 3, repeating; ch2 (D=2) -> SQ2 toggles each cycle.
//  3 EN0 low for 7 cycles at C0=2 -> C0, SQ0 frozen, no TICK0.
//    Re-enable -> next TICK0 after 2 more edges.
//  4 Load ch0=6 at C0=1 -> LOAD_READY 0 next cycle; TICK0 at original boundary.
//    Then TICK0 every 6; LOAD_READY 1 cycle after apply; ch1/ch2 unaffected.
//  5 Load LOAD_DIV=0 to ch1 -> period 2. Load to LOAD_CH=3 -> accepted, no effect, LOAD_READY stays 1.
//  6 RST_N low while load PEND and counters mid-period -> next cycle all C=0, TICK=SQ=0.
//    Divisors back to {2,5,4}; LOAD_READY=1.

Source files
------------

// File: rtl/multi_rate_divider.sv
// multi_rate_divider: NUM_CH independent clock-enable channels with exact integer divisors,
// each producing a one-cycle tick and a near-50% square wave, reprogrammable via a load port.
module multi_rate_divider #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 27,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd100000, 27'd50000000, 27'd100000000},
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] EN,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  input  logic [CH_W-1:0]   LOAD_CH,
  input  logic [CNT_W-1:0]  LOAD_DIV,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] SQ
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state;
  logic [CH_W-1:0] pend_ch;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] div [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] term, app;

  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
    return v < CNT_W'(2) ? CNT_W'(2) : v;
  endfunction

  // a pending load lands on its channel's wrap, or at once if that channel is paused
  always_comb
    for (int i = 0; i < NUM_CH; i++) begin
      term[i] = cnt[i] == div[i] - CNT_W'(1);
      cnt_nxt[i] = term[i] ? '0 : cnt[i] + CNT_W'(1);
      app[i] = state == PEND && pend_ch == CH_W'(i) && (!EN[i] || term[i]);
    end

  always_ff @(posedge CLK)
    if (!RST_N) begin
      state <= IDLE;
      LOAD_READY <= 1'b1;
      pend_ch <= '0;
      pend_div <= '0;
      TICK <= '0;
      SQ <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div[i] <= clamp(DIV_INIT[i*CNT_W +: CNT_W]);
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (app[i]) begin
          div[i] <= pend_div;
          cnt[i] <= '0;
          SQ[i] <= 1'b0;
          TICK[i] <= EN[i];
        end else if (EN[i]) begin
          cnt[i] <= cnt_nxt[i];
          TICK[i] <= term[i];
          SQ[i] <= cnt_nxt[i] >= div[i] - (div[i] >> 1);
        end else
          TICK[i] <= 1'b0;
      if (state == IDLE) begin
        if (LOAD_VALID && 32'(LOAD_CH) < NUM_CH) begin
          state <= PEND;
          LOAD_READY <= 1'b0;
          pend_ch <= LOAD_CH;
          pend_div <= clamp(LOAD_DIV);
        end
      end else if (|app) begin
        state <= IDLE;
        LOAD_READY <= 1'b1;
      end
    end
endmodule
